// File: rtl/miriscv_btb_sa.sv
// Set-associative branch target buffer for the fetch stage.
// Lookup result appears one cycle after pc_i is presented. Updates come from
// the execute feedback path. After reset or invalidate-all, an init sweep
// clears every set, one set per cycle.
module miriscv_btb_sa #(
  parameter  int BTB_SETS = 256,
  parameter  int BTB_WAYS = 2,
  parameter  int PC_LEN   = 32,
  localparam int IDX_W    = $clog2(BTB_SETS),
  localparam int WAY_W    = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1,
  localparam int TAG_W    = PC_LEN - 2 - IDX_W
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [PC_LEN-1:0] pc_i,
  output logic              btb_hit_o,
  output logic [WAY_W-1:0]  btb_way_o,
  output logic [PC_LEN-1:0] btb_target_o,
  output logic              btb_branch_o,
  output logic              btb_jal_o,
  output logic              btb_jalr_o,
  input  logic              fb_btb_upd_i,
  input  logic [PC_LEN-1:0] fb_btb_pc_i,
  input  logic [PC_LEN-1:0] fb_btb_target_i,
  input  logic              fb_btb_branch_i,
  input  logic              fb_btb_jal_i,
  input  logic              fb_btb_jalr_i,
  input  logic              fb_btb_flush_i,
  input  logic              fb_btb_inv_all_i,
  output logic              btb_init_o
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Table storage; kind is packed as {jalr, jal, branch}
  logic [BTB_WAYS-1:0] valid_q [BTB_SETS];
  logic [TAG_W-1:0]    tag_q   [BTB_SETS][BTB_WAYS];
  logic [PC_LEN-1:0]   tgt_q   [BTB_SETS][BTB_WAYS];
  logic [2:0]          kind_q  [BTB_SETS][BTB_WAYS];
  logic [WAY_W-1:0]    rr_q    [BTB_SETS];

  state_e           state_q, state_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             init_q, init_d;

  // Lookup pipeline registers (way contents captured in the lookup cycle)
  logic [BTB_WAYS-1:0] rd_vld_q, rd_vld_d;
  logic [TAG_W-1:0]    rd_tag_q  [BTB_WAYS];
  logic [TAG_W-1:0]    rd_tag_d  [BTB_WAYS];
  logic [PC_LEN-1:0]   rd_tgt_q  [BTB_WAYS];
  logic [PC_LEN-1:0]   rd_tgt_d  [BTB_WAYS];
  logic [2:0]          rd_kind_q [BTB_WAYS];
  logic [2:0]          rd_kind_d [BTB_WAYS];
  logic [TAG_W-1:0]    lk_tag_q, lk_tag_d;
  logic [IDX_W-1:0]    lk_set;

  // Update path
  logic [IDX_W-1:0]    fb_set;
  logic [TAG_W-1:0]    fb_tag;
  logic                fb_hit, fb_free, upd_en, wr_en, clr_en, rr_adv;
  logic [WAY_W-1:0]    fb_hit_way, fb_free_way, wr_way;
  logic [WAY_W-1:0]    rr_nxt;
  logic                sweep_en;
  logic [IDX_W-1:0]    sweep_set;

  logic                unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[1:0], fb_btb_pc_i[1:0]};

  // Sequencer next state: sweep sets 0..BTB_SETS-1, then run until invalidate-all
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (fb_btb_inv_all_i) begin
          cnt_d = '0;
        end else if (cnt_q == (IDX_W+1)'(BTB_SETS-1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (fb_btb_inv_all_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
    init_d = (state_d == ST_INIT);
  end

  // Sequencer state, sweep counter and registered init flag
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
    end
  end

  assign sweep_en   = (state_q == ST_INIT);
  assign sweep_set  = cnt_q[IDX_W-1:0];
  assign btb_init_o = init_q;

  // Update decode: match way, first free way, round-robin victim
  always_comb begin
    fb_set      = fb_btb_pc_i[2 +: IDX_W];
    fb_tag      = fb_btb_pc_i[PC_LEN-1 -: TAG_W];
    fb_hit      = 1'b0;
    fb_hit_way  = '0;
    fb_free     = 1'b0;
    fb_free_way = '0;
    for (int w = BTB_WAYS-1; w >= 0; w--) begin
      if (valid_q[fb_set][w] && (tag_q[fb_set][w] == fb_tag)) begin
        fb_hit     = 1'b1;
        fb_hit_way = WAY_W'(w);
      end
      if (!valid_q[fb_set][w]) begin
        fb_free     = 1'b1;
        fb_free_way = WAY_W'(w);
      end
    end
    upd_en = (state_q == ST_RUN) && fb_btb_upd_i && !fb_btb_inv_all_i;
    wr_en  = upd_en && !fb_btb_flush_i;
    clr_en = upd_en && fb_btb_flush_i && fb_hit;
    rr_adv = wr_en && !fb_hit && !fb_free;
    if (fb_hit) begin
      wr_way = fb_hit_way;
    end else if (fb_free) begin
      wr_way = fb_free_way;
    end else begin
      wr_way = rr_q[fb_set];
    end
    rr_nxt = (BTB_WAYS == 1) ? '0 : rr_q[fb_set] + 1'b1;
  end

  // Valid bits: sweep clear, update set, flush clear
  always_ff @(posedge clk_i) begin
    if (sweep_en) begin
      valid_q[sweep_set] <= '0;
    end
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (wr_en && (wr_way == WAY_W'(w))) begin
        valid_q[fb_set][w] <= 1'b1;
      end
      if (clr_en && (fb_hit_way == WAY_W'(w))) begin
        valid_q[fb_set][w] <= 1'b0;
      end
    end
  end

  // Entry payload; contents are don't-care while the valid bit is clear
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (wr_en && (wr_way == WAY_W'(w))) begin
        tag_q[fb_set][w]  <= fb_tag;
        tgt_q[fb_set][w]  <= fb_btb_target_i;
        kind_q[fb_set][w] <= {fb_btb_jalr_i, fb_btb_jal_i, fb_btb_branch_i};
      end
    end
  end

  // Round-robin victim pointer per set, advanced only on eviction
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int s = 0; s < BTB_SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else if (rr_adv) begin
      rr_q[fb_set] <= rr_nxt;
    end
  end

  // Lookup read: capture the whole set before any same-cycle write lands
  always_comb begin
    lk_set   = pc_i[2 +: IDX_W];
    lk_tag_d = pc_i[PC_LEN-1 -: TAG_W];
    rd_vld_d = (state_q == ST_RUN) ? valid_q[lk_set] : '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      rd_tag_d[w]  = tag_q[lk_set][w];
      rd_tgt_d[w]  = tgt_q[lk_set][w];
      rd_kind_d[w] = kind_q[lk_set][w];
    end
  end

  // Lookup pipeline stage
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rd_vld_q <= '0;
      lk_tag_q <= '0;
      for (int w = 0; w < BTB_WAYS; w++) begin
        rd_tag_q[w]  <= '0;
        rd_tgt_q[w]  <= '0;
        rd_kind_q[w] <= '0;
      end
    end else begin
      rd_vld_q <= rd_vld_d;
      lk_tag_q <= lk_tag_d;
      for (int w = 0; w < BTB_WAYS; w++) begin
        rd_tag_q[w]  <= rd_tag_d[w];
        rd_tgt_q[w]  <= rd_tgt_d[w];
        rd_kind_q[w] <= rd_kind_d[w];
      end
    end
  end

  // Tag compare on the registered lookup; lowest matching way wins
  always_comb begin
    btb_hit_o    = 1'b0;
    btb_way_o    = '0;
    btb_target_o = '0;
    btb_branch_o = 1'b0;
    btb_jal_o    = 1'b0;
    btb_jalr_o   = 1'b0;
    for (int w = BTB_WAYS-1; w >= 0; w--) begin
      if (rd_vld_q[w] && (rd_tag_q[w] == lk_tag_q)) begin
        btb_hit_o    = 1'b1;
        btb_way_o    = (BTB_WAYS == 1) ? '0 : WAY_W'(w);
        btb_target_o = rd_tgt_q[w];
        btb_jalr_o   = rd_kind_q[w][2];
        btb_jal_o    = rd_kind_q[w][1];
        btb_branch_o = rd_kind_q[w][0];
      end
    end
  end

endmodule

// File: tb/tb_miriscv_btb_sa.sv
// Directed bench for miriscv_btb_sa with default parameters (256 sets, 2 ways).
module tb_miriscv_btb_sa;

  localparam int OP_LOOK  = 0;
  localparam int OP_UPD   = 1;
  localparam int OP_FLUSH = 2;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic [31:0] pc_i;
  logic        btb_hit_o;
  logic [0:0]  btb_way_o;
  logic [31:0] btb_target_o;
  logic        btb_branch_o, btb_jal_o, btb_jalr_o;
  logic        fb_btb_upd_i;
  logic [31:0] fb_btb_pc_i, fb_btb_target_i;
  logic        fb_btb_branch_i, fb_btb_jal_i, fb_btb_jalr_i;
  logic        fb_btb_flush_i, fb_btb_inv_all_i;
  logic        btb_init_o;

  int checks   = 0;
  int failures = 0;

  miriscv_btb_sa dut (
    .clk_i            (clk_i),
    .arstn_i          (arstn_i),
    .pc_i             (pc_i),
    .btb_hit_o        (btb_hit_o),
    .btb_way_o        (btb_way_o),
    .btb_target_o     (btb_target_o),
    .btb_branch_o     (btb_branch_o),
    .btb_jal_o        (btb_jal_o),
    .btb_jalr_o       (btb_jalr_o),
    .fb_btb_upd_i     (fb_btb_upd_i),
    .fb_btb_pc_i      (fb_btb_pc_i),
    .fb_btb_target_i  (fb_btb_target_i),
    .fb_btb_branch_i  (fb_btb_branch_i),
    .fb_btb_jal_i     (fb_btb_jal_i),
    .fb_btb_jalr_i    (fb_btb_jalr_i),
    .fb_btb_flush_i   (fb_btb_flush_i),
    .fb_btb_inv_all_i (fb_btb_inv_all_i),
    .btb_init_o       (btb_init_o)
  );

  always #5 clk_i = ~clk_i;

  // kind packing: {jalr, jal, branch}
  typedef struct {
    int          op;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [2:0]  kind;
    logic        e_hit;
    logic        e_way;
    logic [31:0] e_tgt;
    logic [2:0]  e_kind;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_fb(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [2:0] kind, input logic flush);
    fb_btb_pc_i     = pc;
    fb_btb_target_i = tgt;
    fb_btb_branch_i = kind[0];
    fb_btb_jal_i    = kind[1];
    fb_btb_jalr_i   = kind[2];
    fb_btb_flush_i  = flush;
    fb_btb_upd_i    = 1'b1;
  endtask

  task automatic fb_idle();
    fb_btb_upd_i   = 1'b0;
    fb_btb_flush_i = 1'b0;
  endtask

  task automatic add(input int op, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic [2:0] kind, input logic e_hit, input logic e_way,
                     input logic [31:0] e_tgt, input logic [2:0] e_kind);
    vec_t v;
    v.op = op; v.pc = pc; v.tgt = tgt; v.kind = kind;
    v.e_hit = e_hit; v.e_way = e_way; v.e_tgt = e_tgt; v.e_kind = e_kind;
    vecs.push_back(v);
  endtask

  task automatic lookup_chk(input string nm, input logic [31:0] pc, input logic e_hit,
                            input logic e_way, input logic [31:0] e_tgt, input logic [2:0] e_kind);
    pc_i = pc;
    tick();
    chk({nm, "_hit"},  btb_hit_o, e_hit);
    chk({nm, "_way"},  btb_way_o, e_way);
    chk({nm, "_tgt"},  btb_target_o, e_tgt);
    chk({nm, "_kind"}, {btb_jalr_o, btb_jal_o, btb_branch_o}, e_kind);
  endtask

  // Counts cycles with btb_init_o high; optional restart and ignored update inside the sweep
  task automatic run_init(input int restart_at, input int upd_at, output int n, output int hits);
    n = 0;
    hits = 0;
    while (btb_init_o === 1'b1 && n < 2000) begin
      n++;
      if (btb_hit_o !== 1'b0) hits++;
      if (n == restart_at) fb_btb_inv_all_i = 1'b1;
      if (n == upd_at) drive_fb(32'h0000_0040, 32'h0000_0777, 3'b010, 1'b0);
      tick();
      fb_btb_inv_all_i = 1'b0;
      fb_idle();
    end
  endtask

  initial begin
    int n, hits;
    logic [31:0] miss_pcs [5];

    arstn_i          = 1'b0;
    pc_i             = '0;
    fb_btb_pc_i      = '0;
    fb_btb_target_i  = '0;
    fb_btb_branch_i  = 1'b0;
    fb_btb_jal_i     = 1'b0;
    fb_btb_jalr_i    = 1'b0;
    fb_btb_inv_all_i = 1'b0;
    fb_idle();

    // Directed sequence in set 0x40 (pcs 0x100/0x500/0x900/0xD00), then other sets
    add(OP_LOOK,  32'h100, 0, 0,      0, 0, 32'h0,        3'b000);
    add(OP_UPD,   32'h100, 32'h200, 3'b010, 0, 0, 0, 0);
    add(OP_LOOK,  32'h100, 0, 0,      1, 0, 32'h200,      3'b010);
    add(OP_UPD,   32'h500, 32'h600, 3'b001, 0, 0, 0, 0);
    add(OP_UPD,   32'h900, 32'hA00, 3'b100, 0, 0, 0, 0);
    add(OP_LOOK,  32'h100, 0, 0,      0, 0, 32'h0,        3'b000);
    add(OP_LOOK,  32'h500, 0, 0,      1, 1, 32'h600,      3'b001);
    add(OP_LOOK,  32'h900, 0, 0,      1, 0, 32'hA00,      3'b100);
    add(OP_UPD,   32'h500, 32'h300, 3'b001, 0, 0, 0, 0);
    add(OP_LOOK,  32'h500, 0, 0,      1, 1, 32'h300,      3'b001);
    add(OP_FLUSH, 32'h500, 0, 0,      0, 0, 0, 0);
    add(OP_LOOK,  32'h500, 0, 0,      0, 0, 32'h0,        3'b000);
    add(OP_LOOK,  32'h900, 0, 0,      1, 0, 32'hA00,      3'b100);
    add(OP_FLUSH, 32'hD00, 0, 0,      0, 0, 0, 0);
    add(OP_LOOK,  32'h900, 0, 0,      1, 0, 32'hA00,      3'b100);
    add(OP_UPD,   32'hD00, 32'hD10, 3'b010, 0, 0, 0, 0);
    add(OP_LOOK,  32'hD00, 0, 0,      1, 1, 32'hD10,      3'b010);
    add(OP_UPD,   32'h100, 32'h200, 3'b010, 0, 0, 0, 0);
    add(OP_LOOK,  32'h100, 0, 0,      1, 1, 32'h200,      3'b010);
    add(OP_LOOK,  32'hD00, 0, 0,      0, 0, 32'h0,        3'b000);
    add(OP_LOOK,  32'h900, 0, 0,      1, 0, 32'hA00,      3'b100);
    add(OP_UPD,   32'h500, 32'h300, 3'b001, 0, 0, 0, 0);
    add(OP_LOOK,  32'h900, 0, 0,      0, 0, 32'h0,        3'b000);
    add(OP_LOOK,  32'h500, 0, 0,      1, 0, 32'h300,      3'b001);
    add(OP_UPD,   32'h104, 32'h44, 3'b001, 0, 0, 0, 0);
    add(OP_LOOK,  32'h104, 0, 0,      1, 0, 32'h44,       3'b001);
    add(OP_UPD,   32'h3FC, 32'h8000_0000, 3'b100, 0, 0, 0, 0);
    add(OP_LOOK,  32'h3FC, 0, 0,      1, 0, 32'h8000_0000, 3'b100);
    add(OP_LOOK,  32'h3F8, 0, 0,      0, 0, 32'h0,        3'b000);

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_hit",  btb_hit_o, 1'b0);
    chk("rst_init", btb_init_o, 1'b1);
    chk("rst_tgt",  btb_target_o, 32'h0);
    chk("rst_way",  btb_way_o, 1'b0);
    chk("rst_kind", {btb_jalr_o, btb_jal_o, btb_branch_o}, 3'b000);

    // Initial sweep length, lookups miss throughout
    arstn_i = 1'b1;
    pc_i = 32'h100;
    run_init(0, 0, n, hits);
    chk("init_len", n, 256);
    chk("init_hits", hits, 0);

    // Table-driven lookups and updates
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].op == OP_LOOK) begin
        lookup_chk($sformatf("v%0d", i), vecs[i].pc, vecs[i].e_hit, vecs[i].e_way,
                   vecs[i].e_tgt, vecs[i].e_kind);
      end else begin
        drive_fb(vecs[i].pc, vecs[i].tgt, vecs[i].kind, vecs[i].op == OP_FLUSH);
        tick();
        fb_idle();
      end
    end

    // Read-first: lookup and update of the same set in the same cycle
    pc_i = 32'h7FC;
    drive_fb(32'h7FC, 32'h123, 3'b001, 1'b0);
    tick();
    fb_idle();
    chk("rf_same_cycle_hit", btb_hit_o, 1'b0);
    tick();
    chk("rf_next_hit",  btb_hit_o, 1'b1);
    chk("rf_next_way",  btb_way_o, 1'b1);
    chk("rf_next_tgt",  btb_target_o, 32'h123);

    // Invalidate-all in RUN with a simultaneous update that must be dropped
    pc_i = 32'h1234_5600;
    fb_btb_inv_all_i = 1'b1;
    drive_fb(32'hD00, 32'h55, 3'b010, 1'b0);
    tick();
    fb_btb_inv_all_i = 1'b0;
    fb_idle();
    pc_i = 32'h100;
    run_init(0, 200, n, hits);
    chk("inv_init_len", n, 256);
    chk("inv_init_hits", hits, 0);
    miss_pcs[0] = 32'h100; miss_pcs[1] = 32'h500; miss_pcs[2] = 32'hD00;
    miss_pcs[3] = 32'h40;  miss_pcs[4] = 32'h3FC;
    for (int i = 0; i < 5; i++) begin
      pc_i = miss_pcs[i];
      tick();
      chk($sformatf("inv_miss_%0h", miss_pcs[i]), btb_hit_o, 1'b0);
    end

    // Invalidate-all during the sweep restarts it
    pc_i = 32'h1234_5600;
    fb_btb_inv_all_i = 1'b1;
    tick();
    fb_btb_inv_all_i = 1'b0;
    run_init(100, 0, n, hits);
    chk("restart_init_len", n, 356);

    // Table usable again after invalidate
    drive_fb(32'h100, 32'h2468, 3'b001, 1'b0);
    tick();
    fb_idle();
    lookup_chk("post_inv", 32'h100, 1'b1, 1'b0, 32'h2468, 3'b001);

    // Reset mid-operation
    pc_i = 32'h100;
    tick();
    arstn_i = 1'b0;
    #1;
    chk("midrst_hit",  btb_hit_o, 1'b0);
    chk("midrst_init", btb_init_o, 1'b1);
    chk("midrst_tgt",  btb_target_o, 32'h0);
    tick();
    arstn_i = 1'b1;
    run_init(0, 0, n, hits);
    chk("midrst_init_len", n, 256);
    lookup_chk("midrst_miss", 32'h100, 1'b0, 1'b0, 32'h0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
